// File: rtl/booth_seq_divider.sv
// Sequential signed divider (restoring, magnitudes, sign fix-up); `ifdef DIV_ERR_EN adds div_zero/overflow outputs.
// Latency WIDTH_N+2 cycles (2 on divide-by-zero); result held until out_ready, in_ready low while busy.
module booth_seq_divider #(
  parameter int WIDTH_N = 16,
  parameter int WIDTH_D = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_N-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder
`ifdef DIV_ERR_EN
  ,
  output logic               div_zero,
  output logic               overflow
`endif
);

  localparam int CW = $clog2(WIDTH_N);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state_q;
  logic [WIDTH_N-1:0] dvd_q;
  logic [WIDTH_D-1:0] dsr_q;
  logic [WIDTH_D:0]   prem_q;
  logic [CW-1:0]      cnt_q;
  logic               neg_quo_q;
  logic               neg_rem_q;
  logic               dz_q;
  logic [WIDTH_N-1:0] quo_q;
  logic [WIDTH_D-1:0] rem_q;
  logic               in_rdy_q;
  logic               out_vld_q;
`ifdef DIV_ERR_EN
  logic               dz_flag_q;
  logic               ovf_q;
`endif

  logic [WIDTH_N-1:0] dvd_abs;
  logic [WIDTH_D-1:0] dsr_abs;
  logic [WIDTH_D+1:0] prem_sh;
  logic [WIDTH_D+1:0] trial;
  logic [WIDTH_D:0]   prem_d;
  logic [WIDTH_N-1:0] dvd_d;
  logic [WIDTH_N-1:0] quo_fix;
  logic [WIDTH_D-1:0] rem_fix;

  assign dvd_abs = dividend[WIDTH_N-1] ? -dividend : dividend;
  assign dsr_abs = divisor[WIDTH_D-1] ? -divisor : divisor;

  // One restoring step: the dividend MSB enters the partial remainder, the quotient bit enters the dividend LSB.
  assign prem_sh = {prem_q, dvd_q[WIDTH_N-1]};
  assign trial   = prem_sh - {2'b00, dsr_q};
  assign prem_d  = trial[WIDTH_D+1] ? prem_sh[WIDTH_D:0] : trial[WIDTH_D:0];
  assign dvd_d   = {dvd_q[WIDTH_N-2:0], ~trial[WIDTH_D+1]};

  assign quo_fix = dz_q ? {WIDTH_N{1'b1}} : (neg_quo_q ? -dvd_q : dvd_q);
  assign rem_fix = dz_q ? '0 : (neg_rem_q ? -prem_q[WIDTH_D-1:0] : prem_q[WIDTH_D-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      dsr_q     <= '0;
      prem_q    <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
`ifdef DIV_ERR_EN
      dz_flag_q <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            dvd_q     <= dvd_abs;
            dsr_q     <= dsr_abs;
            prem_q    <= '0;
            cnt_q     <= '0;
            neg_quo_q <= dividend[WIDTH_N-1] ^ divisor[WIDTH_D-1];
            neg_rem_q <= dividend[WIDTH_N-1];
            dz_q      <= (divisor == '0);
            in_rdy_q  <= 1'b0;
`ifdef DIV_ERR_EN
            dz_flag_q <= 1'b0;
            ovf_q     <= 1'b0;
`endif
            state_q   <= (divisor == '0) ? FIX : CALC;
          end
        end
        CALC: begin
          dvd_q  <= dvd_d;
          prem_q <= prem_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH_N-1)) begin
            cnt_q   <= '0;
            state_q <= FIX;
          end
        end
        FIX: begin
          quo_q     <= quo_fix;
          rem_q     <= rem_fix;
          out_vld_q <= 1'b1;
`ifdef DIV_ERR_EN
          dz_flag_q <= dz_q;
          // A positive quotient with its MSB set only arises from the most-negative dividend over -1.
          ovf_q     <= ~dz_q & ~neg_quo_q & dvd_q[WIDTH_N-1];
`endif
          state_q   <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_vld_q <= 1'b0;
            in_rdy_q  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_rdy_q;
  assign out_valid = out_vld_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;
`ifdef DIV_ERR_EN
  assign div_zero  = dz_flag_q;
  assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_booth_seq_divider.sv
// Directed bench for booth_seq_divider: integer-arithmetic reference model checked every cycle, plus literal expectations.
module tb_booth_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
`ifdef DIV_ERR_EN
  logic        div_zero;
  logic        overflow;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  booth_seq_divider #(.WIDTH_N(16), .WIDTH_D(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIV_ERR_EN
    ,
    .div_zero  (div_zero),
    .overflow  (overflow)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: truncating signed division on plain integers.
  logic        pending  = 1'b0;
  logic        vld_seen = 1'b0;
  int          cyc      = 0;
  int          exp_lat  = 0;
  logic [15:0] mq;
  logic [7:0]  mr;
  logic        mdz;
  logic        movf;

  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      pending  = 1'b0;
      vld_seen = 1'b0;
    end else begin
      if (pending) cyc++;
      if (out_valid) begin
        chk("vld_has_op", {31'd0, pending}, 32'd1);
        if (pending) begin
          if (!vld_seen) begin
            chk("latency", cyc, exp_lat);
            vld_seen = 1'b1;
          end
          chk("q_model", {16'd0, quotient}, {16'd0, mq});
          chk("r_model", {24'd0, remainder}, {24'd0, mr});
          chk("in_ready_done", {31'd0, in_ready}, 32'd0);
`ifdef DIV_ERR_EN
          chk("div_zero", {31'd0, div_zero}, {31'd0, mdz});
          chk("overflow", {31'd0, overflow}, {31'd0, movf});
`endif
          if (out_ready) pending = 1'b0;
        end
      end else if (pending && cyc > 0) begin
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
      end else if (!pending) begin
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
      end
      if (in_valid && in_ready) begin
        int n, d;
        n = int'($signed(dividend));
        d = int'($signed(divisor));
        mdz  = (d == 0);
        movf = (n == -32768) && (d == -1);
        if (d == 0) begin
          mq = 16'hFFFF;
          mr = 8'h00;
        end else begin
          mq = 16'(n / d);
          mr = 8'(n % d);
        end
        exp_lat  = (d == 0) ? 2 : 18;
        cyc      = 0;
        pending  = 1'b1;
        vld_seen = 1'b0;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the result was consumed.
  task automatic run_op(input logic [15:0] n, input logic [7:0] d, input logic [15:0] eq, input logic [7:0] er,
                        input int hold, input bit early, input bit nxt, input logic [15:0] nn, input logic [7:0] nd);
    int t;
    dividend = n;
    divisor  = d;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    if (early) out_ready = 1'b1;
    t = 0;
    while (!out_valid && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) chk("vld_timeout", {31'd0, out_valid}, 32'd1);
    chk("q_lit", {16'd0, quotient}, {16'd0, eq});
    chk("r_lit", {24'd0, remainder}, {24'd0, er});
    if (nxt) begin
      dividend = nn;
      divisor  = nd;
      in_valid = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_q", {16'd0, quotient}, {16'd0, eq});
      chk("hold_vld", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_vld", {31'd0, out_valid}, 32'd0);
    chk("post_rdy", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_q", {16'd0, quotient}, 32'd0);
    chk("rst_r", {24'd0, remainder}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'd100,   8'd7,     16'h000E, 8'h02, 0, 1'b0, 1'b0, 16'd0, 8'd0);
    run_op(-16'sd100, 8'd7,     16'hFFF2, 8'hFE, 0, 1'b0, 1'b0, 16'd0, 8'd0);
    run_op(16'd100,   -8'sd7,   16'hFFF2, 8'h02, 0, 1'b0, 1'b0, 16'd0, 8'd0);
    run_op(-16'sd100, -8'sd7,   16'h000E, 8'hFE, 0, 1'b1, 1'b0, 16'd0, 8'd0);
    run_op(16'd1234,  8'd0,     16'hFFFF, 8'h00, 0, 1'b0, 1'b0, 16'd0, 8'd0);
    run_op(16'h8000,  8'hFF,    16'h8000, 8'h00, 0, 1'b0, 1'b0, 16'd0, 8'd0);
    // Backpressure with the next operands already offered; they are taken only after the consume.
    run_op(16'd1000,  -8'sd3,   16'hFEB3, 8'h01, 10, 1'b0, 1'b1, 16'd32767, 8'h80);
    run_op(16'd32767, 8'h80,    16'hFF01, 8'h7F, 0, 1'b0, 1'b0, 16'd0, 8'd0);

    // Reset in the 8th CALC cycle must clear everything without a clock edge.
    dividend = 16'd100;
    divisor  = 8'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_in_ready", {31'd0, in_ready}, 32'd1);
    chk("async_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_q", {16'd0, quotient}, 32'd0);
    chk("async_r", {24'd0, remainder}, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    run_op(16'd100,   8'd7,     16'h000E, 8'h02, 0, 1'b0, 1'b0, 16'd0, 8'd0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
